// File: rtl/fpadd_arbiter.sv
// Shares one pipelined single-precision fpadd among NREQ requesters, with per-requester credit counters.
// Define FPADD_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (lowest index wins).
module fpadd_arbiter #(
  parameter int NREQ   = 4,
  parameter int LAT    = 3,
  parameter int OUTMAX = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [31:0]          fp_a,
  output logic [31:0]          fp_b,
  input  logic [31:0]          fp_sum,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_sum,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(OUTMAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(OUTMAX);

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
  } tag_t;

  // Stage 0 travels with fp_a/fp_b; stages 1..LAT track the adder's own LAT stages.
  tag_t          tag_q [0:LAT];
  logic [CW-1:0] cnt_q [NREQ];
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] cnt_inc;
  logic [NREQ-1:0] cnt_dec;
  logic            gnt_vld;
  logic [IW-1:0]   gnt_idx;
  logic [31:0]     a_sel;
  logic [31:0]     b_sel;
  tag_t            rsp_tag;

  assign rsp_tag = tag_q[LAT];

  // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] && (cnt_q[i] < CNT_MAX);
    end
  end

`ifdef FPADD_ARB_RR_EN
  logic [IW-1:0] ptr_q;
  int            rr_cand;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_cand = 0;
    for (int off = 0; off < NREQ; off++) begin
      rr_cand = int'(ptr_q) + off;
      if (rr_cand >= NREQ) rr_cand = rr_cand - NREQ;
      if (!gnt_vld && elig[rr_cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(rr_cand);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (gnt_vld) begin
      ptr_q <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IW'(1);
    end
  end
`else
  // Scanning downward leaves the lowest eligible index as the final winner.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(i);
      end
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    a_sel     = '0;
    b_sel     = '0;
    cnt_inc   = '0;
    cnt_dec   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_vld && gnt_idx == IW'(i)) begin
        req_ready[i] = 1'b1;
        cnt_inc[i]   = 1'b1;
        a_sel        = req_a[32*i +: 32];
        b_sel        = req_b[32*i +: 32];
      end
      if (rsp_tag.vld && rsp_tag.idx == IW'(i)) begin
        cnt_dec[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rsp_valid = cnt_dec;
    rsp_sum   = rsp_tag.vld ? fp_sum : '0;
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      busy = busy | tag_q[k].vld;
    end
    for (int i = 0; i < NREQ; i++) begin
      busy = busy | (cnt_q[i] != '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples its predecessor's old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fp_a <= '0;
      fp_b <= '0;
      // NOTE: the tag array is reset because its valid bits qualify responses; the adder's data pipe is not.
      for (int k = 0; k <= LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      if (gnt_vld) begin
        fp_a     <= a_sel;
        fp_b     <= b_sel;
        tag_q[0] <= '{vld: 1'b1, idx: gnt_idx};
      end else begin
        fp_a     <= '0;
        fp_b     <= '0;
        tag_q[0] <= '0;
      end
      for (int k = 1; k <= LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  // Accept and response for the same requester in one cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (cnt_inc[i] && !cnt_dec[i]) begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end else if (cnt_dec[i] && !cnt_inc[i]) begin
          cnt_q[i] <= cnt_q[i] - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Scoreboard bench for fpadd_arbiter: directed stimulus pushes expected responses, a monitor pops and compares.
// Grant-order expectations follow FPADD_ARB_RR_EN in the same way as the design.
module tb_fpadd_arbiter;

  localparam int NREQ   = 4;
  localparam int LAT    = 3;
  localparam int OUTMAX = 2;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic [31:0]         fp_a;
  logic [31:0]         fp_b;
  logic [31:0]         fp_sum;
  logic [NREQ-1:0]     rsp_valid;
  logic [31:0]         rsp_sum;
  logic                busy;

  fpadd_arbiter #(.NREQ(NREQ), .LAT(LAT), .OUTMAX(OUTMAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .fp_a      (fp_a),
    .fp_b      (fp_b),
    .fp_sum    (fp_sum),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in adder for normal operands whose sum is exactly representable (truncating normalisation).
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    longint ma, mb, s, mag;
    int     ea, eb, e, da, db;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = (ea == 0) ? 64'sd0 : longint'({1'b1, a[22:0]});
    mb = (eb == 0) ? 64'sd0 : longint'({1'b1, b[22:0]});
    if (ma == 0) ea = eb;
    if (mb == 0) eb = ea;
    e  = (ea < eb) ? ea : eb;
    da = (ea - e > 30) ? 30 : ea - e;
    db = (eb - e > 30) ? 30 : eb - e;
    ma = ma <<< da;
    mb = mb <<< db;
    if (a[31]) ma = -ma;
    if (b[31]) mb = -mb;
    s = ma + mb;
    if (s == 0) return 32'h0000_0000;
    mag = (s < 0) ? -s : s;
    while (mag >= (64'sd1 <<< 24)) begin mag = mag >>> 1; e++; end
    while (mag <  (64'sd1 <<< 23)) begin mag = mag <<< 1; e--; end
    return {(s < 0), 8'(e), mag[22:0]};
  endfunction

  logic [31:0] add_pipe [1:LAT];
  initial for (int k = 1; k <= LAT; k++) add_pipe[k] = '0;
  always @(posedge clk) begin
    add_pipe[1] <= fp_add(fp_a, fp_b);
    for (int k = 2; k <= LAT; k++) add_pipe[k] <= add_pipe[k-1];
  end
  assign fp_sum = add_pipe[LAT];

  typedef struct {
    logic [NREQ-1:0] vld;
    logic [31:0]     sum;
    int              cyc;
  } exp_t;

  exp_t sb [$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation, on its exact cycle.
  always @(negedge clk) begin
    if (rst_n && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid 0x%0h sum 0x%0h, expected no response", rsp_valid, rsp_sum);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'(e.vld));
        check("rsp_sum",   64'(rsp_sum),   64'(e.sum));
        check("rsp_cycle", 64'(cyc),       64'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  // Inputs are already driven; check the grant before the edge and log the expected response.
  task automatic step(input logic [NREQ-1:0] exp_gnt, input logic [31:0] exp_sum, input string name);
    @(negedge clk);
    check(name, 64'(req_ready), 64'(exp_gnt));
    if (exp_gnt != '0) sb.push_back('{vld: exp_gnt, sum: exp_sum, cyc: cyc + LAT + 1});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain"}, 64'(sb.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    check({name, "_busy_idle"}, 64'(busy), 64'(0));
  endtask

  logic [NREQ-1:0] cont_gnt [0:9];
  logic [NREQ-1:0] cred_gnt [0:11];

  initial begin
`ifdef FPADD_ARB_RR_EN
    cont_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
`else
    cont_gnt = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100};
`endif
    cred_gnt = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100,
                 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;

    #2;
    check("reset_req_ready", 64'(req_ready), 64'(0));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_sum",   64'(rsp_sum),   64'(0));
    check("reset_busy",      64'(busy),      64'(0));
    check("reset_fp_a",      64'(fp_a),      64'(0));
    check("reset_fp_b",      64'(fp_b),      64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention: everyone valid, 1.5 + 1.5 = 3.0
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h3FC0_0000, 32'h3FC0_0000);
    req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) step(cont_gnt[c], 32'h4040_0000, "contend_gnt");
    req_valid = '0;
    drain("contend");

    // Single operation: 1.0 + 2.0 = 3.0
    set_op(0, 32'h3F80_0000, 32'h4000_0000);
    req_valid = 4'b0001;
    step(4'b0001, 32'h4040_0000, "single_gnt");
    req_valid = '0;
    check("single_busy", 64'(busy), 64'(1));
    drain("single");

    // Credit limit on requester 2: 1.0 + 1.0 = 2.0
    set_op(2, 32'h3F80_0000, 32'h3F80_0000);
    req_valid = 4'b0100;
    for (int c = 0; c < 12; c++) step(cred_gnt[c], 32'h4000_0000, "credit_gnt");
    req_valid = '0;
    drain("credit");

    // Cancelling operands, then a large-magnitude near-cancel, back to back
    set_op(1, 32'h4040_0000, 32'hC040_0000);
    req_valid = 4'b0010;
    step(4'b0010, 32'h0000_0000, "cancel_gnt");
    set_op(3, 32'hD57F_D554, 32'h54FF_FEAE);
    req_valid = 4'b1000;
    step(4'b1000, 32'hD4FF_ABFA, "nearcancel_gnt");
    req_valid = '0;
    drain("cancel");

    // Reset mid-operation: grants 0,1,3,2 leave the round-robin pointer at 3
    set_op(0, 32'h3F80_0000, 32'h3F80_0000);
    req_valid = 4'b0001;
    step(4'b0001, 32'h4000_0000, "rst_pre_gnt0");
    set_op(1, 32'h3F80_0000, 32'h3F80_0000);
    req_valid = 4'b0010;
    step(4'b0010, 32'h4000_0000, "rst_pre_gnt1");
    set_op(3, 32'h3F80_0000, 32'h3F80_0000);
    req_valid = 4'b1000;
    step(4'b1000, 32'h4000_0000, "rst_pre_gnt3");
    set_op(2, 32'h4000_0000, 32'h4000_0000);
    req_valid = 4'b0100;
    step(4'b0100, 32'h4080_0000, "rst_pre_gnt2");
    req_valid = '0;
    check("rst_pre_fp_a",      64'(fp_a),      64'(32'h4000_0000));
    check("rst_pre_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
    check("rst_pre_busy",      64'(busy),      64'(1));
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_mid_rsp_sum",   64'(rsp_sum),   64'(0));
    check("rst_mid_fp_a",      64'(fp_a),      64'(0));
    check("rst_mid_fp_b",      64'(fp_b),      64'(0));
    check("rst_mid_busy",      64'(busy),      64'(0));
    check("rst_mid_req_ready", 64'(req_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_busy", 64'(busy), 64'(0));
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h3FC0_0000, 32'h3FC0_0000);
    req_valid = 4'b1111;
    step(4'b0001, 32'h4040_0000, "post_rst_gnt");
    req_valid = '0;
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
